// File: rtl/text_scan_renderer.sv
// Raster text-screen renderer: scans COLUMNS x ROWS glyph cells, fetches code and font row, emits one dot per enabled cycle.
// Optional INVERSE_VIDEO_EN: text_data carries an extra top bit that inverts the glyph's dots.
module text_scan_renderer #(
  parameter int unsigned COLUMNS      = 40,
  parameter int unsigned ROWS         = 25,
  parameter int unsigned GLYPH_WIDTH  = 8,
  parameter int unsigned GLYPH_HEIGHT = 8,
  parameter int unsigned CHAR_BITS    = 7
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  output logic [$clog2(COLUMNS*ROWS)-1:0]         text_address,
`ifdef INVERSE_VIDEO_EN
  input  logic [CHAR_BITS:0]                      text_data,
`else
  input  logic [CHAR_BITS-1:0]                    text_data,
`endif
  output logic [CHAR_BITS-1:0]                    glyph_character,
  output logic [$clog2(GLYPH_HEIGHT)-1:0]         glyph_y,
  input  logic [GLYPH_WIDTH-1:0]                  glyph_row,
  output logic                                    dot,
  output logic                                    dot_valid,
  output logic [$clog2(COLUMNS*GLYPH_WIDTH)-1:0]  dot_x,
  output logic [$clog2(ROWS*GLYPH_HEIGHT)-1:0]    dot_y,
  output logic                                    frame_end
);

  localparam int unsigned ADDR_W = $clog2(COLUMNS*ROWS);
  localparam int unsigned X_W    = $clog2(COLUMNS*GLYPH_WIDTH);
  localparam int unsigned Y_W    = $clog2(ROWS*GLYPH_HEIGHT);
  localparam int unsigned GX_W   = $clog2(GLYPH_WIDTH);
  localparam int unsigned GY_W   = $clog2(GLYPH_HEIGHT);
  localparam int unsigned COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [GX_W-1:0]  GX_LAST  = GX_W'(GLYPH_WIDTH - 1);
  localparam logic [GY_W-1:0]  GY_LAST  = GY_W'(GLYPH_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [GX_W-1:0]  gx_cnt;
  logic [GY_W-1:0]  gy_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  logic [X_W-1:0]   scan_x;
  logic [Y_W-1:0]   scan_y;
  logic             scan_last;

  logic             s1_valid;
  logic [GX_W-1:0]  s1_gx;
  logic [X_W-1:0]   s1_x;
  logic [Y_W-1:0]   s1_y;
  logic             s1_last;
  logic             dot_bit;
`ifdef INVERSE_VIDEO_EN
  logic             s1_inv;
`endif

  // Nested raster counters: dot within glyph, column, glyph row, text row.
  always_ff @(posedge clock) begin
    if (reset) begin
      gx_cnt  <= '0;
      col_cnt <= '0;
      gy_cnt  <= '0;
      row_cnt <= '0;
    end else if (enable) begin
      if (gx_cnt == GX_LAST) begin
        gx_cnt <= '0;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          if (gy_cnt == GY_LAST) begin
            gy_cnt  <= '0;
            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
          end else begin
            gy_cnt <= gy_cnt + GY_W'(1);
          end
        end else begin
          col_cnt <= col_cnt + COL_W'(1);
        end
      end else begin
        gx_cnt <= gx_cnt + GX_W'(1);
      end
    end
  end

  always_comb begin
    text_address = ADDR_W'(row_cnt) * ADDR_W'(COLUMNS) + ADDR_W'(col_cnt);
    scan_x       = X_W'(col_cnt) * X_W'(GLYPH_WIDTH) + X_W'(gx_cnt);
    scan_y       = Y_W'(row_cnt) * Y_W'(GLYPH_HEIGHT) + Y_W'(gy_cnt);
    scan_last    = (gx_cnt == GX_LAST) && (col_cnt == COL_LAST) &&
                   (gy_cnt == GY_LAST) && (row_cnt == ROW_LAST);
  end

  // Stage 1: latch character code and pixel position; font lookup happens against these.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid        <= 1'b0;
      glyph_character <= '0;
      glyph_y         <= '0;
      s1_gx           <= '0;
      s1_x            <= '0;
      s1_y            <= '0;
      s1_last         <= 1'b0;
`ifdef INVERSE_VIDEO_EN
      s1_inv          <= 1'b0;
`endif
    end else begin
      s1_valid        <= enable;
      glyph_character <= text_data[CHAR_BITS-1:0];
      glyph_y         <= gy_cnt;
      s1_gx           <= gx_cnt;
      s1_x            <= scan_x;
      s1_y            <= scan_y;
      s1_last         <= scan_last;
`ifdef INVERSE_VIDEO_EN
      s1_inv          <= text_data[CHAR_BITS];
`endif
    end
  end

  // Leftmost dot is the font row's MSB.
  always_comb begin
    dot_bit = glyph_row[GX_LAST - s1_gx];
`ifdef INVERSE_VIDEO_EN
    dot_bit = dot_bit ^ s1_inv;
`endif
  end

  // Stage 2: registered dot and coordinates.
  always_ff @(posedge clock) begin
    if (reset) begin
      dot_valid <= 1'b0;
      dot       <= 1'b0;
      dot_x     <= '0;
      dot_y     <= '0;
      frame_end <= 1'b0;
    end else begin
      dot_valid <= s1_valid;
      dot       <= dot_bit;
      dot_x     <= s1_x;
      dot_y     <= s1_y;
      frame_end <= s1_valid & s1_last;
    end
  end

endmodule

// File: tb/tb_text_scan_renderer.sv
// Scoreboard bench for text_scan_renderer: reference pixels pushed at issue, monitor compares on dot_valid.
module tb_text_scan_renderer;

  localparam int COLS = 40;
  localparam int ROWS = 25;
  localparam int GW   = 8;
  localparam int GH   = 8;
  localparam int SW   = COLS * GW;
  localparam int SH   = ROWS * GH;
  localparam int NPIX = SW * SH;
`ifdef INVERSE_VIDEO_EN
  localparam int TD_W = 8;
`else
  localparam int TD_W = 7;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [9:0]      text_address;
  logic [TD_W-1:0] text_data;
  logic [6:0]      glyph_character;
  logic [2:0]      glyph_y;
  logic [7:0]      glyph_row;
  logic            dot;
  logic            dot_valid;
  logic [8:0]      dot_x;
  logic [7:0]      dot_y;
  logic            frame_end;

  logic [TD_W-1:0] tmem [1024];

  typedef struct {
    int unsigned cyc;
    int          x;
    int          y;
    logic        d;
    logic        fe;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          p = 0;
  int          fe_exp = 0;
  int          fe_seen = 0;
  int unsigned cyc = 0;
  logic [6:0]  exp_gc = '0;
  logic [2:0]  exp_gy = '0;

  function automatic logic [7:0] font(input logic [6:0] c, input logic [2:0] r);
    if (c == 7'd65) return 8'b0001_1000;
    return 8'(({1'b0, c} * 8'd37) ^ ({5'd0, r} * 8'd29) ^ 8'h5A);
  endfunction

  // Reference: dot at screen (x,y) from character cell lookup and font bit, MSB leftmost.
  function automatic logic ref_dot(input int x, input int y);
    logic [TD_W-1:0] ch;
    logic [7:0]      bits;
    logic            d;
    ch   = tmem[(y / GH) * COLS + x / GW];
    bits = font(ch[6:0], 3'(y % GH));
    d    = bits[GW - 1 - (x % GW)];
`ifdef INVERSE_VIDEO_EN
    d    = d ^ ch[7];
`endif
    return d;
  endfunction

  assign text_data = tmem[text_address];
  assign glyph_row = font(glyph_character, glyph_y);

  text_scan_renderer dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .text_address    (text_address),
    .text_data       (text_data),
    .glyph_character (glyph_character),
    .glyph_y         (glyph_y),
    .glyph_row       (glyph_row),
    .dot             (dot),
    .dot_valid       (dot_valid),
    .dot_x           (dot_x),
    .dot_y           (dot_y),
    .frame_end       (frame_end)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One stimulus cycle, driven just after the rising edge.
  task automatic step(input bit en, input bit rst);
    int x, y, a;
    exp_t e;
    x = p % SW;
    y = p / SW;
    a = (y / GH) * COLS + x / GW;
    chk("text_address", text_address, a);
    chk("glyph_character", glyph_character, exp_gc);
    chk("glyph_y", glyph_y, exp_gy);
    enable = en;
    reset  = rst;
    if (rst) begin
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      p = 0;
      exp_gc = '0;
      exp_gy = '0;
    end else begin
      exp_gc = tmem[a][6:0];
      exp_gy = 3'(y % GH);
      if (en) begin
        e.cyc = cyc + 2;
        e.x   = x;
        e.y   = y;
        e.d   = ref_dot(x, y);
        e.fe  = (x == SW - 1) && (y == SH - 1);
        if (e.fe) fe_exp++;
        q.push_back(e);
        p = (p + 1) % NPIX;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: every valid dot must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (dot_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dot: got dot_valid at (%0d,%0d) expected none", dot_x, dot_y);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("dot_x", dot_x, e.x);
        chk("dot_y", dot_y, e.y);
        chk("dot", dot, e.d);
        chk("frame_end", frame_end, e.fe);
        if (frame_end === 1'b1) fe_seen++;
      end
    end else begin
      chk("frame_end_idle", frame_end, 0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_dot: got no dot_valid expected pixel (%0d,%0d)", e.x, e.y);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    int guard;
    for (int i = 0; i < 1024; i++) tmem[i] = TD_W'(8'hC1);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dot_valid", dot_valid, 0);
    chk("rst_dot", dot, 0);
    chk("rst_dot_x", dot_x, 0);
    chk("rst_dot_y", dot_y, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_glyph_character", glyph_character, 0);
    chk("rst_glyph_y", glyph_y, 0);
    chk("rst_text_address", text_address, 0);

    // Full frame plus wrap with uniform text.
    for (int i = 0; i < NPIX + 20; i++) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    chk("frame_end_once", fe_seen, 1);

    // Random text, reset mid-scan at pixel (100,3).
    for (int i = 0; i < 1024; i++) tmem[i] = TD_W'($urandom);
    guard = 0;
    while (p != 3 * SW + 100 && guard < NPIX) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("reach_100_3", p, 3 * SW + 100);
    step(1'b1, 1'b1);
    chk("post_reset_dot_valid", dot_valid, 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

    // Bubbles: strict toggle, then random enable.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) != 0, 1'b0);

    repeat (4) step(1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);
    chk("frame_end_total", fe_seen, fe_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_scan_renderer.md
Name: text_scan_renderer

Overview:
- Parametrised successor to the single-glyph character_rom.
- Scans a full text screen of COLUMNS x ROWS characters, each GLYPH_WIDTH x GLYPH_HEIGHT dots, in raster order, producing one dot per enabled cycle.
- Fetches character codes from an external text memory and glyph rows from an external font memory through a 2-stage pipeline.
- Sits between the text buffer/font ROM and the video timing/output logic.

Parameters:
- COLUMNS, 40, characters per text row
- ROWS, 25, text rows per screen
- GLYPH_WIDTH, 8, dots per glyph row (bit GLYPH_WIDTH-1 is the leftmost dot)
- GLYPH_HEIGHT, 8, glyph rows per character
- CHAR_BITS, 7, character code width

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  when high, the current scan pixel enters the pipeline and the scan counters advance
- text_address  output  $clog2(COLUMNS*ROWS)  equals row*COLUMNS+column of the current scan pixel (combinational from counters)
- text_data  input  CHAR_BITS (CHAR_BITS+1 with INVERSE_VIDEO_EN)  character at text_address, same-cycle combinational reply
- glyph_character  output  CHAR_BITS  stage-1 character code (register output)
- glyph_y  output  $clog2(GLYPH_HEIGHT)  stage-1 glyph row index (register output)
- glyph_row  input  GLYPH_WIDTH  font row for glyph_character/glyph_y, same-cycle combinational reply
- dot  output  1  rendered dot
- dot_valid  output  1  dot and coordinates valid this cycle
- dot_x  output  $clog2(COLUMNS*GLYPH_WIDTH)  screen x of dot
- dot_y  output  $clog2(ROWS*GLYPH_HEIGHT)  screen y of dot
- frame_end  output  1  high with dot_valid on the last pixel of a frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high, port names clock and reset.
- Scan counters: glyph_x, column, glyph_y counter, row. All advance only on enable.
  - glyph_x increments; at GLYPH_WIDTH-1 it wraps to 0 and column increments.
  - At the last column, column wraps to 0 and the glyph_y counter increments.
  - At GLYPH_HEIGHT-1, the glyph_y counter wraps to 0 and row increments.
  - At the last row, row wraps to 0 (new frame).
- Stage 1 (every edge): stage-1 valid <= enable; capture text_data, glyph_x, glyph_y, screen x/y, last-pixel flag.
- Stage 2 (every edge):
  - dot_valid <= stage-1 valid
  - dot <= glyph_row[GLYPH_WIDTH-1-stage1_glyph_x]
  - dot_x/dot_y/frame_end registered from stage 1
- Latency: a pixel presented during enabled cycle N appears at the outputs in cycle N+2. The pipeline never stalls; enable low inserts a bubble (dot_valid 0).
- Screen coordinates: x = column*GLYPH_WIDTH+glyph_x, y = row*GLYPH_HEIGHT+glyph_y, unsigned, no overflow at legal values.
- frame_end: high only on pixel (COLUMNS*GLYPH_WIDTH-1, ROWS*GLYPH_HEIGHT-1), and only when dot_valid is high.
- Reset values: all counters 0, both valid bits 0, dot 0, dot_x 0, dot_y 0, frame_end 0, glyph_character 0, glyph_y 0.
- Reset mid-operation: in-flight pixels are discarded (dot_valid 0 in the cycle after reset). The first pixel emitted after reset is (0,0).
- Reset has priority over enable.

Optional Feature:
- Macro: INVERSE_VIDEO_EN.
- Defined:
  - text_data is CHAR_BITS+1 wide; bit CHAR_BITS is the inverse flag.
  - glyph_character takes the low CHAR_BITS bits.
  - dot = glyph bit XOR the pipelined inverse flag.
- Undefined: text_data is CHAR_BITS wide; no inversion logic.

Test Plan:
- Default params; text memory all 65; font model returns 8'b00011000 for (65, any row); reset 1 cycle, then enable held 1 -> text_address 0 for 8 cycles then 1; first dot_valid 2 cycles after first enabled cycle; dots for x=0..7 are 0,0,0,1,1,0,0,0.
- Continue scan -> after 320 enabled cycles, dot_y=1 and dot_x=0, text_address back to 0; after 2560 enabled cycles, text_address=40 and dot_y=8.
- Run 64000 enabled cycles -> frame_end high exactly once, with dot_x=319, dot_y=199; next valid dot is (0,0) with frame_end 0.
- Enable toggled 1,0,1,0 -> dot_valid follows the same pattern delayed 2 cycles; dot_x sequence contiguous, no skip or duplicate.
- Assert reset for one cycle while scan is at pixel (100,3) with enable high -> dot_valid 0 next cycle; first valid dot after reset is (0,0).
- INVERSE_VIDEO_EN defined; text_data=8'hC1 -> glyph_character=65; dots for x=0..7 are 1,1,1,0,0,1,1,1.
